fb_read_arbiter: RTL and testbench
==================================

# fb_read_arbiter

Shares the single read port of the frame-buffer memory between the HDMI scan-out fetch (display requester) and a secondary requester (processor/debug readback, "aux"). Display reads get fixed priority with a scroll offset applied to their address; aux reads get the remaining slots. Each read returns on the owning requester's port. The block sits between the processor's frame memory (address out, 8-bit colour back) and the HDMI transmitter's pixel fetch.

## Interface
- `ADDR_W`, 24: memory address width.
- `DATA_W`, 8: pixel/colour data width.
- `OFS_W`, 18: scroll offset width.
- `FB_WORDS`, 230400: frame-buffer size in words; display address wrap modulus.
- `RD_LAT`, 2: memory read latency in cycles, from `mem_rd` to valid `mem_rdata` (≥1).
- `STARVE_MAX`, 15: aux wait limit before forced grant.

- `clk` in 1: single clock, 50 MHz domain.
- `rst` in 1: asynchronous, active-low reset.
- `disp_sof` in 1: start-of-frame pulse; latches `offset`.
- `offset` in OFS_W: scroll offset for display reads.
- `disp_req` in 1: display read request.
- `disp_addr` in ADDR_W: display linear pixel address, < FB_WORDS.
- `disp_gnt` out 1: display request accepted this cycle.
- `disp_rvalid` out 1: display read data valid.
- `disp_rdata` out DATA_W: display read data.
- `aux_req` in 1: aux read request.
- `aux_addr` in ADDR_W: aux address, passed through untranslated.
- `aux_gnt` out 1: aux request accepted this cycle.
- `aux_rvalid` out 1: aux read data valid.
- `aux_rdata` out DATA_W: aux read data.
- `mem_rd` out 1: memory read strobe.
- `mem_addr` out ADDR_W: memory address.
- `mem_rdata` in DATA_W: memory read data.

## Operation
- **Handshake.** A requester holds `req` and its address stable until it sees `gnt` high. `gnt` is combinational from the `req` inputs and the starvation state. The address is accepted on the clock edge that ends the grant cycle. One grant at most per cycle.
- **Arbitration (per cycle).**
  - Display only requesting: display wins.
  - Aux only requesting: aux wins.
  - Both requesting: display wins, unless the starvation counter has reached STARVE_MAX, in which case aux wins.
- **Starvation counter.**
  - Increments (saturating) each cycle `aux_req` is high without `aux_gnt`.
  - Clears on `aux_gnt` and whenever `aux_req` is low.
- **Offset latch.**
  - `offset_q` loads `offset` on the cycle `disp_sof` is high.
  - If `offset` ≥ FB_WORDS, `offset_q` loads 0.
  - `disp_sof` coincident with a display grant: that grant already uses the new `offset_q`, i.e. the latch is bypassed.
- **Address translation.**
  - Display address: sum = `disp_addr` + `offset_q`, computed at ADDR_W+1 bits.
  - If sum ≥ FB_WORDS, subtract FB_WORDS. Single subtract suffices, since both operands are < FB_WORDS.
  - Aux address passes through unchanged.
- **Return steering.**
  - An owner tag (valid, is_aux) shift register, RD_LAT+1 deep, tracks each issued read.
  - `mem_rdata` is registered into the owner's `rdata`; that owner's `rvalid` pulses for one cycle.
  - Non-owner `rdata` holds its last value.
- Reads are never dropped or reordered. Throughput is one read per cycle sustained.

## Timing
- **Grant cycle T:**
  - T+1: `mem_rd` and `mem_addr` are registered outputs.
  - T+1+RD_LAT: `mem_rdata` is valid.
  - T+2+RD_LAT: owner `rvalid`/`rdata` are high/valid.
  - Total latency: RD_LAT+2 cycles (4 at default).
- **Idle cycle:** `mem_rd` = 0 and `mem_addr` holds its last value.
- **Reset values:**
  - `disp_gnt`, `aux_gnt`, `mem_rd`, `disp_rvalid`, `aux_rvalid` = 0.
  - `mem_addr`, `disp_rdata`, `aux_rdata` = 0.
  - `offset_q` = 0, starvation counter = 0, tag pipeline all invalid.
- **Reset mid-operation:** in-flight reads are discarded; no `rvalid` is produced for them after reset release.
- **Grants during reset:** both `gnt` are forced 0 while `rst` is low.

## Configuration
- `FB_ARB_STARVE_EN` defined: starvation counter and forced aux grant included, as described above.
- Undefined: strict display priority. Counter logic is removed and aux is granted only in cycles with `disp_req` low.

## Structure
- Shared package `fb_pkg`:
  - `FB_WORDS` and `OFS_W` defaults.
  - `owner_t` typedef: 1-bit enum `OWN_DISP` / `OWN_AUX`.
  - `rd_tag_t` struct: valid + owner.
- One sub-module, `fb_addr_wrap`: registered-free combinational modular adder (`disp_addr`, `offset_q` → wrapped address), reused by the HDMI scroll logic.

## Test plan
- **Display only.** `disp_addr` = 100, `offset` = 0 latched by `disp_sof` → `mem_addr` = 100 at T+1; `disp_rvalid` at T+4 with `rdata` = `mem[100]`; `aux_rvalid` stays 0.
- **Wrap.**
  - `offset` = 230000, `disp_addr` = 500 → `mem_addr` = 100.
  - `offset` = 230400 (out of range) → `offset_q` = 0, `mem_addr` = 500.
- **Contention (`FB_ARB_STARVE_EN` set).** `disp_req` and `aux_req` held high continuously → `aux_gnt` exactly once every 16 cycles; `disp_gnt` in the other 15; return order matches grant order.
- **Contention (macro undefined).** Same stimulus → `aux_gnt` never asserts; dropping `disp_req` for one cycle yields one `aux_gnt` that cycle.
- **Back-to-back interleave.** Alternating grants D, A, D, A → `disp_rvalid` and `aux_rvalid` alternate 4 cycles after each grant, each with the correct data.
- **Mid-flight reset.** Assert `rst` low 2 cycles after 3 grants, release → no `rvalid` pulses; all outputs 0 during reset; first post-reset grant returns with normal latency.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer types and default geometry for the read arbiter and scroll logic.
package fb_pkg;

  localparam int unsigned FB_WORDS_DEFAULT = 230400;
  localparam int unsigned OFS_W_DEFAULT    = 18;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_AUX  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/fb_addr_wrap.sv
// Combinational modular adder: (addr + offset) mod FB_WORDS, both operands < FB_WORDS.
module fb_addr_wrap #(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned OFS_W    = 18,
  parameter int unsigned FB_WORDS = 230400
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [OFS_W-1:0]  offset,
  output logic [ADDR_W-1:0] wrapped_addr
);

  localparam int unsigned SUM_W = ADDR_W + 1;

  logic [SUM_W-1:0] sum;

  // One conditional subtract is enough because the sum is below 2*FB_WORDS.
  always_comb begin
    sum          = SUM_W'(addr) + SUM_W'(offset);
    wrapped_addr = ADDR_W'(sum);
    if (sum >= SUM_W'(FB_WORDS)) begin
      wrapped_addr = ADDR_W'(sum - SUM_W'(FB_WORDS));
    end
  end

endmodule

// File: rtl/fb_read_arbiter.sv
// Frame-buffer read-port arbiter: display has priority (with scroll offset), aux
// gets the remaining slots; read data is steered back to the issuing requester.
// Optional feature macro: FB_ARB_STARVE_EN (aux starvation counter + forced grant).
module fb_read_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OFS_W      = OFS_W_DEFAULT,
  parameter int unsigned FB_WORDS   = FB_WORDS_DEFAULT,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_sof,
  input  logic [OFS_W-1:0]  offset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Elaboration guard: a zero latency or zero starvation limit is meaningless.
  if (RD_LAT < 1 || STARVE_MAX < 1) begin : g_param_check
    $error("fb_read_arbiter: RD_LAT and STARVE_MAX must be >= 1");
  end

  logic [OFS_W-1:0]  offset_q;
  logic [OFS_W-1:0]  offset_in;
  logic [OFS_W-1:0]  offset_eff;
  logic [ADDR_W-1:0] disp_addr_wrap;
  logic              force_aux;
  rd_tag_t           new_tag;
  rd_tag_t [RD_LAT:0] tag_q;
  rd_tag_t           ret_tag;

  // Out-of-range scroll offsets collapse to 0; a start-of-frame bypasses the latch.
  always_comb begin
    offset_in  = (32'(offset) >= FB_WORDS) ? '0 : offset;
    offset_eff = disp_sof ? offset_in : offset_q;
  end

  fb_addr_wrap #(
    .ADDR_W  (ADDR_W),
    .OFS_W   (OFS_W),
    .FB_WORDS(FB_WORDS)
  ) u_addr_wrap (
    .addr        (disp_addr),
    .offset      (offset_eff),
    .wrapped_addr(disp_addr_wrap)
  );

`ifdef FB_ARB_STARVE_EN
  localparam int unsigned CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CNT_W-1:0] starve_cnt;

  // Counts consecutive cycles aux waits; saturates at the forced-grant limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!aux_req || aux_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt < CNT_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign force_aux = (starve_cnt >= CNT_W'(STARVE_MAX));
`else
  assign force_aux = 1'b0;
`endif

  // Per-cycle grant: display first unless aux has waited too long; none in reset.
  always_comb begin
    disp_gnt = 1'b0;
    aux_gnt  = 1'b0;
    if (rst) begin
      if (aux_req && (!disp_req || force_aux)) begin
        aux_gnt = 1'b1;
      end else if (disp_req) begin
        disp_gnt = 1'b1;
      end
    end
  end

  // Scroll offset latched at start of frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offset_q <= '0;
    end else if (disp_sof) begin
      offset_q <= offset_in;
    end
  end

  // Memory request register; address holds while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_rd <= disp_gnt | aux_gnt;
      if (aux_gnt) begin
        mem_addr <= aux_addr;
      end else if (disp_gnt) begin
        mem_addr <= disp_addr_wrap;
      end
    end
  end

  // Owner tag for the read issued this cycle.
  always_comb begin
    new_tag.valid = disp_gnt | aux_gnt;
    new_tag.owner = aux_gnt ? OWN_AUX : OWN_DISP;
  end

  // Tag shift register; the last stage lines up with valid mem_rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= {tag_q[RD_LAT-1:0], new_tag};
    end
  end

  assign ret_tag = tag_q[RD_LAT];

  // Steer returning data to its owner; the other port keeps its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_rvalid <= 1'b0;
      aux_rvalid  <= 1'b0;
      disp_rdata  <= '0;
      aux_rdata   <= '0;
    end else begin
      disp_rvalid <= ret_tag.valid && (ret_tag.owner == OWN_DISP);
      aux_rvalid  <= ret_tag.valid && (ret_tag.owner == OWN_AUX);
      if (ret_tag.valid && (ret_tag.owner == OWN_DISP)) begin
        disp_rdata <= mem_rdata;
      end
      if (ret_tag.valid && (ret_tag.owner == OWN_AUX)) begin
        aux_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Randomised bench for fb_read_arbiter against a queue-based reference model.
module tb_fb_read_arbiter;

  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned OFS_W      = 18;
  localparam int          FB_W       = 230400;
  localparam int unsigned RD_LAT     = 2;
  localparam int          STARVE_MAX = 15;
  localparam int          LAT        = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              disp_sof = 1'b0;
  logic [OFS_W-1:0]  offset = '0;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              aux_req = 1'b0;
  logic [ADDR_W-1:0] aux_addr = '0;
  logic              aux_gnt;
  logic              aux_rvalid;
  logic [DATA_W-1:0] aux_rdata;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  fb_read_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .disp_sof   (disp_sof),
    .offset     (offset),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_gnt   (disp_gnt),
    .disp_rvalid(disp_rvalid),
    .disp_rdata (disp_rdata),
    .aux_req    (aux_req),
    .aux_addr   (aux_addr),
    .aux_gnt    (aux_gnt),
    .aux_rvalid (aux_rvalid),
    .aux_rdata  (aux_rdata),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  // Memory contents as a fixed function of address.
  function automatic logic [7:0] memf(input logic [23:0] a);
    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Memory: data for the address presented in a cycle appears RD_LAT cycles later.
  logic [23:0] dl [RD_LAT];
  always @(posedge clk) begin
    dl[0] <= mem_addr;
    for (int i = 1; i < int'(RD_LAT); i++) dl[i] <= dl[i-1];
  end
  assign mem_rdata = memf(dl[RD_LAT-1]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model state.
  typedef struct {
    int          due;
    bit          aux;
    logic [7:0]  data;
  } ret_t;

  ret_t        rq[$];
  int          cyc = 0;
  int          m_cnt = 0;
  int          m_offq = 0;
  bit          e_rd = 1'b0;
  logic [23:0] e_addr = '0;
  logic [7:0]  e_drd = '0;
  logic [7:0]  e_ard = '0;

  // Compare process: every mid-cycle, check all outputs and advance the model.
  always @(negedge clk) begin : model
    bit          e_dv, e_av, dg, ag;
    int          off_in, eff;
    logic [23:0] ga;
    ret_t        r;
    cyc++;
    if (!rst) begin
      chk("rst_disp_gnt", disp_gnt, 0);
      chk("rst_aux_gnt", aux_gnt, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_disp_rvalid", disp_rvalid, 0);
      chk("rst_aux_rvalid", aux_rvalid, 0);
      chk("rst_disp_rdata", disp_rdata, 0);
      chk("rst_aux_rdata", aux_rdata, 0);
      rq.delete();
      m_cnt = 0; m_offq = 0; e_rd = 1'b0; e_addr = '0; e_drd = '0; e_ard = '0;
    end else begin
      e_dv = 1'b0; e_av = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        if (r.aux) begin e_av = 1'b1; e_ard = r.data; end
        else       begin e_dv = 1'b1; e_drd = r.data; end
      end
      chk("mem_rd", mem_rd, e_rd);
      chk("mem_addr", mem_addr, e_addr);
      chk("disp_rvalid", disp_rvalid, e_dv);
      chk("aux_rvalid", aux_rvalid, e_av);
      chk("disp_rdata", disp_rdata, e_drd);
      chk("aux_rdata", aux_rdata, e_ard);
`ifdef FB_ARB_STARVE_EN
      ag = aux_req && (!disp_req || m_cnt >= STARVE_MAX);
`else
      ag = aux_req && !disp_req;
`endif
      dg = disp_req && !ag;
      chk("disp_gnt", disp_gnt, dg);
      chk("aux_gnt", aux_gnt, ag);
      off_in = (int'(offset) >= FB_W) ? 0 : int'(offset);
      eff = disp_sof ? off_in : m_offq;
      if (disp_sof) m_offq = off_in;
      m_cnt = (aux_req && !ag) ? ((m_cnt < STARVE_MAX) ? m_cnt + 1 : STARVE_MAX) : 0;
      ga = ag ? aux_addr : 24'((int'(disp_addr) + eff) % FB_W);
      e_rd = dg || ag;
      if (e_rd) begin
        e_addr = ga;
        r.due = cyc + LAT; r.aux = ag; r.data = memf(ga);
        rq.push_back(r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One display request with no competition; ends at mid-cycle of T+1.
  task automatic issue_disp(input bit sof, input int off, input int addr);
    tick();
    disp_sof = sof; offset = OFS_W'(off); disp_req = 1'b1; disp_addr = ADDR_W'(addr);
    tick();
    disp_sof = 1'b0; disp_req = 1'b0;
    @(negedge clk);
  endtask

  int n_ag, n_dg, first_ag, nrv, dprob;
  bit dgs, ags;

  initial begin
    #1 rst = 1'b0;
    disp_req = 1'b1; aux_req = 1'b1;
    repeat (3) tick();
    tick();
    rst = 1'b1; disp_req = 1'b0; aux_req = 1'b0;
    tick();

    // Display only, offset 0
    issue_disp(1'b1, 0, 100);
    chk("disp_only_mem_rd", mem_rd, 1);
    chk("disp_only_mem_addr", mem_addr, 100);
    tick(); tick(); tick();
    @(negedge clk);
    chk("disp_only_rvalid", disp_rvalid, 1);
    chk("disp_only_rdata", disp_rdata, memf(24'd100));
    chk("disp_only_aux_rvalid", aux_rvalid, 0);

    // Wrap, out-of-range offset, latched offset without a grant
    issue_disp(1'b1, 230000, 500);
    chk("wrap_mem_addr", mem_addr, 100);
    issue_disp(1'b1, 230400, 500);
    chk("ofs_oor_mem_addr", mem_addr, 500);
    tick();
    disp_sof = 1'b1; offset = 18'd1000;
    issue_disp(1'b0, 5, 230000);
    chk("ofs_latched_mem_addr", mem_addr, 600);
    repeat (6) tick();

    // Contention: both held high
    tick();
    disp_req = 1'b1; disp_addr = 24'd1234; aux_req = 1'b1; aux_addr = 24'hABCDEF;
    n_ag = 0; n_dg = 0; first_ag = -1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (aux_gnt) begin n_ag++; if (first_ag < 0) first_ag = i; end
      if (disp_gnt) n_dg++;
      tick();
    end
`ifdef FB_ARB_STARVE_EN
    chk("contention_aux_gnts", n_ag, 2);
    chk("contention_first_aux", first_ag, 15);
    chk("contention_disp_gnts", n_dg, 30);
`else
    chk("contention_aux_gnts", n_ag, 0);
    chk("contention_disp_gnts", n_dg, 32);
`endif
    disp_req = 1'b0;
    @(negedge clk);
    chk("drop_disp_aux_gnt", aux_gnt, 1);
    chk("drop_disp_disp_gnt", disp_gnt, 0);
    tick();
    aux_req = 1'b0;
    repeat (8) tick();

    // Back-to-back interleave D, A, D, A
    for (int k = 0; k < 4; k++) begin
      tick();
      disp_req = (k % 2 == 0); aux_req = (k % 2 != 0);
      disp_addr = ADDR_W'(2000 + k); aux_addr = ADDR_W'(24'h300000 + k);
    end
    tick();
    disp_req = 1'b0; aux_req = 1'b0;
    repeat (8) tick();

    // Mid-flight reset after three grants
    for (int k = 0; k < 3; k++) begin
      tick();
      disp_req = 1'b1; disp_addr = ADDR_W'(k * 1000 + 7);
    end
    tick();
    disp_req = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    nrv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (disp_rvalid || aux_rvalid) nrv++;
      tick();
    end
    chk("post_reset_no_rvalid", nrv, 0);
    issue_disp(1'b0, 0, 777);
    chk("post_reset_mem_addr", mem_addr, 777);
    tick(); tick(); tick();
    @(negedge clk);
    chk("post_reset_rvalid", disp_rvalid, 1);
    chk("post_reset_rdata", disp_rdata, memf(24'd777));
    repeat (4) tick();

    // Random traffic honouring the request/grant handshake
    for (int i = 0; i < 4000; i++) begin
      dprob = (i < 2000) ? 60 : 97;
      @(negedge clk);
      dgs = disp_gnt; ags = aux_gnt;
      tick();
      if (!disp_req || dgs) begin
        disp_req  = ($urandom_range(0, 99) < dprob);
        disp_addr = ADDR_W'($urandom_range(0, FB_W - 1));
      end
      if (!aux_req || ags) begin
        aux_req  = ($urandom_range(0, 99) < 50);
        aux_addr = ADDR_W'($urandom);
      end
      disp_sof = ($urandom_range(0, 63) == 0);
      offset   = OFS_W'($urandom_range(0, (1 << OFS_W) - 1));
      if (rst && $urandom_range(0, 499) == 0) rst = 1'b0;
      else if (!rst) rst = 1'($urandom_range(0, 1));
    end
    tick();
    rst = 1'b1; disp_req = 1'b0; aux_req = 1'b0; disp_sof = 1'b0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
